bunny_hit_ctrl: RTL and testbench
=================================

# bunny_hit_ctrl

Upstream stage of the hit LED indicator. It compares the bunny's height against the obstacle stream, registers collisions, and emits a single-cycle `hit` pulse. The pulse drives the LED block's `hit` input and the score/lives display. It also owns the lives counter, a post-hit invulnerability window and the game-over flag.

## Interface
- `BUNNY_X`, 100: left column of the bunny sprite, in pixels.
- `BUNNY_W`, 16: bunny width in pixels. The hit zone is `BUNNY_X .. BUNNY_X+BUNNY_W-1`.
- `LIVES_INIT`, 3: lives loaded at game start (1..7).
- `INVULN_CYCLES`, 5000000: invulnerability length in clocks. Matches the LED red hold. Benches override to 20.
- `clk` in 1: system clock. One clock domain; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `game_active` in 1: high while a round is running.
- `bunny_y` in 8: bunny height above ground. 0 means on the ground.
- `obs_valid` in 1: an obstacle is on screen.
- `obs_x` in 10: obstacle left column.
- `obs_h` in 8: obstacle height.
- `hit` out 1: one-cycle pulse per accepted collision.
- `lives` out 3: remaining lives.
- `invuln` out 1: high while the invulnerability window runs.
- `game_over` out 1: high once lives reach 0. Held until exit.

## Operation
- Collision term (combinational, unsigned compares):
  - `obs_valid && obs_x >= BUNNY_X && obs_x <= BUNNY_X+BUNNY_W-1 && bunny_y < obs_h`.
  - The sum is computed at 11 bits, so there is no wrap.
- The collision term is registered into `collide_q` each cycle. `collide_q` clears when `game_active` is low.
- FSM states:
  - IDLE
    - `lives=LIVES_INIT`, `hit=0`.
    - Goes to PLAY on `game_active=1`.
  - PLAY
    - If `game_active=0`, go to IDLE. This takes priority.
    - Else if `collide_q=1`: assert `hit` and decrement `lives`.
      - If the new `lives=0`, go to OVER.
      - Otherwise load the timer with `INVULN_CYCLES-1` and go to INVULN.
  - INVULN
    - `invuln=1`. `collide_q` is ignored.
    - The timer decrements each cycle.
    - At 0, go to PLAY. A collision still present then causes a new hit on the next PLAY cycle. There is no edge requirement.
    - If `game_active=0`, go to IDLE immediately.
  - OVER
    - `game_over=1`. No further hits.
    - `lives` holds 0.
    - Goes to IDLE when `game_active=0`.
- `lives` never underflows. A decrement occurs only in PLAY, where `lives>=1`.
- Reset values: state IDLE, `lives=LIVES_INIT`, `hit=0`, `invuln=0`, `game_over=0`, `collide_q=0`, timer 0.
- Reset mid-window or in OVER returns everything to the reset values on the next edge. No residual pulse.

## Timing
- Inputs sampled at edge N set `collide_q` after N.
- `hit`, the `lives` update and `invuln` are visible after edge N+1. Latency is 2 clocks from input to `hit`.
- `hit` is high for exactly one cycle.
- `invuln` rises in the same cycle `hit` falls. It stays high for exactly `INVULN_CYCLES` cycles.
- Earliest re-hit: `INVULN_CYCLES+1` cycles after the previous `hit`.
- On the final life, `hit` and `game_over` assert in the same cycle. `invuln` stays 0.
- `game_active` falling on the same edge as a collision: IDLE wins and no `hit` is emitted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `bunny_pkg`:
  - state enum (`ST_IDLE`, `ST_PLAY`, `ST_INVULN`, `ST_OVER`)
  - screen-width constants: X 10 bits, Y 8 bits
  - default `LIVES_INIT` and `INVULN_CYCLES`
- Sub-module `hit_window_timer`:
  - loadable down-counter, 32 bits
  - `load`/`busy`/`done` interface
  - reused by the LED block later
- The top holds the compare, `collide_q`, the FSM and the lives register.

## Test plan
- Reset, then `game_active=1`, `obs_x=105`, `obs_h=20`, `bunny_y=0` → `hit` pulse 2 cycles later, `lives` 3→2, `invuln` high for 20 cycles.
- Same setup with `bunny_y=20`, or `obs_x=116`, or `obs_x=99` → no `hit` (height and column boundaries).
- Collision held continuously → hits at cycles t, t+21 and t+42. `lives` goes 2, 1, 0. `game_over` rises with the third `hit`; no further pulses.
- `game_active` drops on the same edge as a collision → no `hit`; state IDLE with `lives=3`. Re-raising starts PLAY cleanly.
- `rst` asserted mid-INVULN (timer 10) → next edge has `invuln=0`, `lives=3`, `hit=0`, `game_over=0`.
- In OVER, toggle `game_active` 1→0→1 → `game_over` clears and `lives` is reloaded to 3.

Source files
------------

// File: rtl/bunny_pkg.sv
// rtl/bunny_pkg.sv - shared types and constants for the bunny hit controller
package bunny_pkg;

  localparam int X_W     = 10;
  localparam int XC_W    = X_W + 1;
  localparam int Y_W     = 8;
  localparam int LIVES_W = 3;
  localparam int TIMER_W = 32;

  localparam int LIVES_INIT_DEF    = 3;
  localparam int INVULN_CYCLES_DEF = 5000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_INVULN = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

endpackage

// File: rtl/hit_window_timer.sv
// rtl/hit_window_timer.sv - loadable down-counter timing a post-hit window
// busy_o spans load_val_i+1 cycles after the load; done_o marks the last of them.
module hit_window_timer
  import bunny_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               busy_o,
  output logic               done_o
);

  logic [TIMER_W-1:0] cnt_q;
  logic               armed_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (load_i) begin
      cnt_q   <= load_val_i;
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) begin
        armed_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - TIMER_W'(1);
      end
    end
  end

  assign busy_o = armed_q;
  assign done_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/bunny_hit_ctrl.sv
// rtl/bunny_hit_ctrl.sv - collision detect, hit pulse, lives and invulnerability control
module bunny_hit_ctrl
  import bunny_pkg::*;
#(
  parameter int BUNNY_X       = 100,
  parameter int BUNNY_W       = 16,
  parameter int LIVES_INIT    = LIVES_INIT_DEF,
  parameter int INVULN_CYCLES = INVULN_CYCLES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               game_active_i,
  input  logic [Y_W-1:0]     bunny_y_i,
  input  logic               obs_valid_i,
  input  logic [X_W-1:0]     obs_x_i,
  input  logic [Y_W-1:0]     obs_h_i,
  output logic               hit_o,
  output logic [LIVES_W-1:0] lives_o,
  output logic               invuln_o,
  output logic               game_over_o
);

  // Zone bounds are one bit wider than obs_x so the upper bound cannot wrap.
  localparam logic [XC_W-1:0]    ZONE_LO    = XC_W'(BUNNY_X);
  localparam logic [XC_W-1:0]    ZONE_HI    = XC_W'(BUNNY_X + BUNNY_W - 1);
  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [TIMER_W-1:0] WIN_LOAD   = TIMER_W'(INVULN_CYCLES - 1);

  state_e             state_q, state_d;
  logic               collide_q, collide_d;
  logic               hit_q, hit_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               invuln_q, invuln_d;
  logic               game_over_q, game_over_d;
  logic               tmr_load, tmr_busy, tmr_done;

  assign collide_d = game_active_i && obs_valid_i
                     && ({1'b0, obs_x_i} >= ZONE_LO)
                     && ({1'b0, obs_x_i} <= ZONE_HI)
                     && (bunny_y_i < obs_h_i);

  hit_window_timer u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (!game_active_i),
    .load_i     (tmr_load),
    .load_val_i (WIN_LOAD),
    .busy_o     (tmr_busy),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    hit_d    = 1'b0;
    lives_d  = lives_q;
    tmr_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (game_active_i) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (!game_active_i) begin
          state_d = ST_IDLE;
        end else if (collide_q) begin
          hit_d   = 1'b1;
          lives_d = lives_q - LIVES_W'(1);
          if (lives_q == LIVES_W'(1)) begin
            state_d = ST_OVER;
          end else begin
            tmr_load = 1'b1;
            state_d  = ST_INVULN;
          end
        end
      end
      ST_INVULN: begin
        if (!game_active_i) state_d = ST_IDLE;
        else if (tmr_done)  state_d = ST_PLAY;
      end
      ST_OVER: begin
        if (!game_active_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) lives_d = LIVES_LOAD;
    game_over_d = (state_d == ST_OVER);
    // The window flag trails the timer by one cycle so it rises as hit falls.
    invuln_d    = tmr_busy && game_active_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      collide_q   <= 1'b0;
      hit_q       <= 1'b0;
      lives_q     <= LIVES_LOAD;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      collide_q   <= collide_d;
      hit_q       <= hit_d;
      lives_q     <= lives_d;
      invuln_q    <= invuln_d;
      game_over_q <= game_over_d;
    end
  end

  assign hit_o       = hit_q;
  assign lives_o     = lives_q;
  assign invuln_o    = invuln_q;
  assign game_over_o = game_over_q;

endmodule

// File: tb/tb_bunny_hit_ctrl.sv
// tb/tb_bunny_hit_ctrl.sv - directed self-checking bench for bunny_hit_ctrl
module tb_bunny_hit_ctrl;

  logic       clk;
  logic       rst;
  logic       game_active;
  logic [7:0] bunny_y;
  logic       obs_valid;
  logic [9:0] obs_x;
  logic [7:0] obs_h;
  logic       hit;
  logic [2:0] lives;
  logic       invuln;
  logic       game_over;

  int total = 0;
  int bad   = 0;
  int cnt_inv, cnt_hit, nh;
  int hcyc [3];
  logic [2:0] hlives [3];
  logic       hgo [3];
  logic       hinv [3];
  logic [9:0] bx [3];
  logic [7:0] byv [3];

  bunny_hit_ctrl #(
    .BUNNY_X       (100),
    .BUNNY_W       (16),
    .LIVES_INIT    (3),
    .INVULN_CYCLES (20)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .game_active_i (game_active),
    .bunny_y_i     (bunny_y),
    .obs_valid_i   (obs_valid),
    .obs_x_i       (obs_x),
    .obs_h_i       (obs_h),
    .hit_o         (hit),
    .lives_o       (lives),
    .invuln_o      (invuln),
    .game_over_o   (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; game_active = 1'b0; bunny_y = 8'd0;
    obs_valid = 1'b0; obs_x = 10'd0; obs_h = 8'd0;
    step(); step();
    chk("rst_hit", 32'(hit), 0);
    chk("rst_lives", 32'(lives), 3);
    chk("rst_invuln", 32'(invuln), 0);
    chk("rst_game_over", 32'(game_over), 0);
    rst = 1'b0;
    step();

    // basic hit: 2-cycle latency, lives 3->2, 20-cycle window
    game_active = 1'b1; obs_valid = 1'b1; obs_x = 10'd105; obs_h = 8'd20; bunny_y = 8'd0;
    step();
    chk("lat1_hit", 32'(hit), 0);
    step();
    chk("lat2_hit", 32'(hit), 1);
    chk("lat2_lives", 32'(lives), 2);
    chk("lat2_invuln", 32'(invuln), 0);
    obs_valid = 1'b0;
    step();
    chk("post_hit", 32'(hit), 0);
    chk("post_invuln", 32'(invuln), 1);
    cnt_inv = 1; cnt_hit = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (invuln === 1'b1) cnt_inv++;
      if (hit === 1'b1) cnt_hit++;
    end
    chk("invuln_len", 32'(cnt_inv), 20);
    chk("invuln_nohit", 32'(cnt_hit), 0);
    chk("invuln_lives", 32'(lives), 2);

    // height and column boundaries that must not hit
    bx[0] = 10'd105; byv[0] = 8'd20;
    bx[1] = 10'd116; byv[1] = 8'd0;
    bx[2] = 10'd99;  byv[2] = 8'd0;
    for (int k = 0; k < 3; k++) begin
      obs_valid = 1'b1; obs_x = bx[k]; bunny_y = byv[k]; obs_h = 8'd20;
      cnt_hit = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        if (hit === 1'b1) cnt_hit++;
      end
      chk($sformatf("miss_%0d", k), 32'(cnt_hit), 0);
      obs_valid = 1'b0;
      step(); step();
    end
    chk("miss_lives", 32'(lives), 2);

    // continuous collision at the inner edges of the zone until game over
    game_active = 1'b0;
    step();
    chk("idle_reload", 32'(lives), 3);
    game_active = 1'b1; obs_valid = 1'b1; obs_x = 10'd115; obs_h = 8'd20; bunny_y = 8'd19;
    nh = 0;
    for (int i = 1; i <= 80; i++) begin
      step();
      if (hit === 1'b1) begin
        if (nh < 3) begin
          hcyc[nh] = i; hlives[nh] = lives; hgo[nh] = game_over; hinv[nh] = invuln;
        end
        nh++;
      end
    end
    chk("cont_nhits", 32'(nh), 3);
    chk("cont_first", 32'(hcyc[0]), 2);
    chk("cont_gap1", 32'(hcyc[1] - hcyc[0]), 21);
    chk("cont_gap2", 32'(hcyc[2] - hcyc[1]), 21);
    chk("cont_lives0", 32'(hlives[0]), 2);
    chk("cont_lives1", 32'(hlives[1]), 1);
    chk("cont_lives2", 32'(hlives[2]), 0);
    chk("cont_go0", 32'(hgo[0]), 0);
    chk("cont_go2", 32'(hgo[2]), 1);
    chk("cont_inv2", 32'(hinv[2]), 0);
    chk("over_lives", 32'(lives), 0);
    chk("over_flag", 32'(game_over), 1);
    chk("over_invuln", 32'(invuln), 0);

    // leave OVER by toggling game_active
    game_active = 1'b0; obs_valid = 1'b0;
    step();
    chk("exit_go", 32'(game_over), 0);
    chk("exit_lives", 32'(lives), 3);
    game_active = 1'b1;
    step();
    chk("replay_go", 32'(game_over), 0);
    chk("replay_lives", 32'(lives), 3);

    // game_active drops on the edge that would take the hit
    obs_valid = 1'b1; obs_x = 10'd105; obs_h = 8'd20; bunny_y = 8'd0;
    step();
    game_active = 1'b0;
    step();
    chk("drop_hit", 32'(hit), 0);
    chk("drop_lives", 32'(lives), 3);
    step();
    chk("drop_hit2", 32'(hit), 0);
    game_active = 1'b1; obs_valid = 1'b0;
    step(); step();
    chk("rearm_hit", 32'(hit), 0);
    chk("rearm_lives", 32'(lives), 3);
    obs_valid = 1'b1;
    step(); step();
    chk("rearm_newhit", 32'(hit), 1);
    chk("rearm_newlives", 32'(lives), 2);
    obs_valid = 1'b0;

    // reset in the middle of the window (timer at 10)
    for (int i = 0; i < 9; i++) step();
    chk("mid_invuln", 32'(invuln), 1);
    rst = 1'b1;
    step();
    chk("mrst_invuln", 32'(invuln), 0);
    chk("mrst_lives", 32'(lives), 3);
    chk("mrst_hit", 32'(hit), 0);
    chk("mrst_go", 32'(game_over), 0);
    rst = 1'b0;
    step();
    chk("mrst_after_invuln", 32'(invuln), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
